// File: rtl/lac_pkg.sv
// Shared constants and helpers for the carry-lookahead down counter.
// Slices are fixed at 4 bits, so every counter width is a whole number of slices.
package lac_pkg;

    localparam int LAC_SLICE_W = 4;
    localparam int LAC_MAX_W   = 64;

    // A width is usable only if it is a non-empty whole number of slices
    // and fits the all-ones helper below.
    function automatic logic lac_width_ok(input int width);
        return (width >= LAC_SLICE_W) && (width % LAC_SLICE_W == 0) && (width <= LAC_MAX_W);
    endfunction

    function automatic int lac_num_slices(input int width);
        return width / LAC_SLICE_W;
    endfunction

    // Two's-complement -1 at the given width, right-aligned in a 64-bit word.
    function automatic logic [LAC_MAX_W-1:0] lac_all_ones(input int width);
        logic [LAC_MAX_W-1:0] ones;
        ones = '1;
        return ones >> (LAC_MAX_W - width);
    endfunction

endpackage

// File: rtl/lac_dec_slice_4bit.sv
// One 4-bit carry-lookahead slice that adds 4'b1111 (i.e. -1) plus a carry-in.
// Chaining these with cin=0 at the bottom yields Q-1, with cout low only for Q==0.
module lac_dec_slice_4bit
    import lac_pkg::*;
(
    input  logic [LAC_SLICE_W-1:0] a,
    input  logic                   cin,
    output logic [LAC_SLICE_W-1:0] s,
    output logic                   cout
);

    localparam logic [LAC_SLICE_W-1:0] B_OPERAND = 4'b1111;

    logic [LAC_SLICE_W-1:0] g;
    logic [LAC_SLICE_W-1:0] p;
    logic [LAC_SLICE_W:0]   c;

    assign g = a & B_OPERAND;
    assign p = a ^ B_OPERAND;

    // Fully expanded lookahead terms; no ripple between bit positions.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s    = p ^ c[LAC_SLICE_W-1:0];
    assign cout = c[LAC_SLICE_W];

endmodule

// File: rtl/lac_down_counter.sv
// Loadable, enable-gated down counter with a registered terminal-count pulse.
// The decrement is formed by a chain of 4-bit CLA slices adding all-ones.
module lac_down_counter
    import lac_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter bit STOP_AT_ZERO = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    input  logic             T,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             tc
);

    localparam int               NUM_SLICES = lac_num_slices(WIDTH);
    localparam logic [WIDTH-1:0] ALL_ONES   = WIDTH'(lac_all_ones(WIDTH));

    generate
        if (!lac_width_ok(WIDTH)) begin : g_bad_width
            $error("lac_down_counter: WIDTH must be a multiple of 4 in [4,64]");
        end
    endgenerate

    logic [WIDTH-1:0]    q_reg;
    logic [WIDTH-1:0]    q_next;
    logic                tc_reg;
    logic                tc_next;
    logic [WIDTH-1:0]    sum;
    logic [NUM_SLICES:0] carry;
    logic                borrow;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
            lac_dec_slice_4bit u_slice (
                .a    (q_reg[gi*LAC_SLICE_W +: LAC_SLICE_W]),
                .cin  (carry[gi]),
                .s    (sum[gi*LAC_SLICE_W +: LAC_SLICE_W]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    // Adding -1 carries out for every nonzero Q, so a missing carry means Q was 0.
    assign borrow = ~carry[NUM_SLICES];

    always_comb begin
        q_next  = q_reg;
        tc_next = 1'b0;
        if (load) begin
            q_next = D;
        end else if (T) begin
            if (!borrow) begin
                q_next  = sum;
                tc_next = ~|sum;
            end else begin
                q_next = STOP_AT_ZERO ? '0 : ALL_ONES;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_reg  <= '0;
            tc_reg <= 1'b0;
        end else begin
            q_reg  <= q_next;
            tc_reg <= tc_next;
        end
    end

    assign Q    = q_reg;
    assign tc   = tc_reg;
    assign zero = ~|q_reg;

endmodule
